// File: rtl/addr_decoding_pkg.sv
// Shared constants and types for the data-memory address decoder.
package addr_decoding_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam logic [ADDR_W-1:0] DMEM_BASE_ADDR = 32'h0000_192E;
    localparam int unsigned DMEM_DEPTH = 1024;
    localparam int unsigned ERR_CNT_W = 16;

    typedef struct packed {
        logic                 valid;
        logic [ADDR_W-1:0]    addr;
        logic                 is_write;
        logic [ERR_CNT_W-1:0] count;
    } err_state_t;

    // Inclusive unsigned window check.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] first,
                                       input logic [ADDR_W-1:0] last);
        return (addr >= first) && (addr <= last);
    endfunction

endpackage

// File: rtl/addr_decoding_err_capture.sv
// Out-of-range access capture: sticky first-fault record plus saturating fault counter.
module addr_err_capture
    import addr_decoding_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 err_event_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic                 we_i,
    input  logic                 err_clr_i,
    output logic                 err_valid_o,
    output logic [ADDR_W-1:0]    err_addr_o,
    output logic                 err_is_write_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    err_state_t err_q, err_d;

    always_comb begin
        err_d = err_q;
        // Clear beats a simultaneous event; that event is dropped.
        if (err_clr_i) begin
            err_d = '0;
        end else if (err_event_i) begin
            if (!err_q.valid) begin
                err_d.valid    = 1'b1;
                err_d.addr     = addr_i;
                err_d.is_write = we_i;
            end
            if (err_q.count != {ERR_CNT_W{1'b1}}) begin
                err_d.count = err_q.count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_valid_o    = err_q.valid;
    assign err_addr_o     = err_q.addr;
    assign err_is_write_o = err_q.is_write;
    assign err_count_o    = err_q.count;

endmodule

// File: rtl/addr_decoding.sv
// Combinational data-memory window decoder with optional error capture
// (enabled by defining ADDR_DECODE_ERR_CAPTURE_EN).
module addr_decoding
    import addr_decoding_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = DMEM_BASE_ADDR,
    parameter int unsigned       DEPTH     = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              WE,
    input  logic              access_valid,
    input  logic              err_clr,
    output logic              CS,
    output logic              iWE,
    output logic [ADDR_W-1:0] iAddress
`ifdef ADDR_DECODE_ERR_CAPTURE_EN
    ,
    output logic                 err_valid,
    output logic [ADDR_W-1:0]    err_addr,
    output logic                 err_is_write,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam logic [ADDR_W-1:0] LastAddr = BASE_ADDR + ADDR_W'(DEPTH) - 32'd1;

    always_comb begin
        CS       = in_window(address, BASE_ADDR, LastAddr);
        iWE      = WE & CS;
        iAddress = CS ? (address - BASE_ADDR) : '0;
    end

`ifdef ADDR_DECODE_ERR_CAPTURE_EN
    addr_err_capture u_err_capture (
        .clk_i          (clk),
        .rst_i          (rst),
        .err_event_i    (access_valid & ~CS),
        .addr_i         (address),
        .we_i           (WE),
        .err_clr_i      (err_clr),
        .err_valid_o    (err_valid),
        .err_addr_o     (err_addr),
        .err_is_write_o (err_is_write),
        .err_count_o    (err_count)
    );
`else
    // Capture logic absent; these inputs are kept only for a stable interface.
    logic unused_ports;
    assign unused_ports = ^{clk, rst, access_valid, err_clr};
`endif

endmodule

// File: tb/tb_addr_decoding.sv
// Randomized self-checking bench for addr_decoding; covers error capture when
// ADDR_DECODE_ERR_CAPTURE_EN is defined.
module tb_addr_decoding;

    localparam longint unsigned Base  = 64'h192E;
    localparam longint unsigned Depth = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic        WE = 1'b0;
    logic        access_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic        CS;
    logic        iWE;
    logic [31:0] iAddress;
`ifdef ADDR_DECODE_ERR_CAPTURE_EN
    logic        err_valid;
    logic [31:0] err_addr;
    logic        err_is_write;
    logic [15:0] err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference error state
    bit          m_valid = 0;
    longint      m_addr = 0;
    bit          m_wr = 0;
    longint      m_count = 0;

    always #5 clk = ~clk;

    addr_decoding dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .WE           (WE),
        .access_valid (access_valid),
        .err_clr      (err_clr),
        .CS           (CS),
        .iWE          (iWE),
        .iAddress     (iAddress)
`ifdef ADDR_DECODE_ERR_CAPTURE_EN
        ,
        .err_valid    (err_valid),
        .err_addr     (err_addr),
        .err_is_write (err_is_write),
        .err_count    (err_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_hit(input logic [31:0] a);
        longint unsigned v = longint'(a);
        return v >= Base && v < Base + Depth;
    endfunction

    task automatic check_decode(input string tag);
        bit hit = ref_hit(address);
        check({tag, ".CS"}, {31'd0, CS}, {31'd0, hit});
        check({tag, ".iWE"}, {31'd0, iWE}, {31'd0, hit & WE});
        check({tag, ".iAddr"}, iAddress, hit ? 32'(longint'(address) - Base) : 32'd0);
    endtask

    task automatic check_err(input string tag);
`ifdef ADDR_DECODE_ERR_CAPTURE_EN
        check({tag, ".valid"}, {31'd0, err_valid}, {31'd0, m_valid});
        check({tag, ".addr"}, err_addr, 32'(m_addr));
        check({tag, ".wr"}, {31'd0, err_is_write}, {31'd0, m_wr});
        check({tag, ".count"}, {16'd0, err_count}, 32'(m_count));
`endif
    endtask

    // Drive one cycle; optionally check decode and the post-edge error state.
    task automatic cycle(input logic [31:0] a, input bit we, input bit av, input bit clr,
                         input bit r, input bit do_check, input string tag);
        @(negedge clk);
        address = a; WE = we; access_valid = av; err_clr = clr; rst = r;
        #1;
        if (do_check) check_decode(tag);
        @(posedge clk);
        if (r || clr) begin
            m_valid = 0; m_addr = 0; m_wr = 0; m_count = 0;
        end else if (av && !ref_hit(a)) begin
            if (!m_valid) begin
                m_valid = 1; m_addr = longint'(a); m_wr = we;
            end
            if (m_count < 65535) m_count++;
        end
        #1;
        if (do_check) check_err(tag);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(3))
            0: return $urandom;
            1: return 32'(Base + longint'($urandom_range(Depth - 1)));
            2: return 32'(Base + Depth - 3 + longint'($urandom_range(5)));
            default: return 32'(Base - 3 + longint'($urandom_range(5)));
        endcase
    endfunction

    initial begin
        cycle(32'h0, 0, 0, 0, 1, 1, "reset");
        cycle(32'h193D, 1, 0, 0, 0, 1, "mid_wr");
        cycle(32'h192E, 0, 0, 0, 0, 1, "first");
        cycle(32'h1D2D, 1, 0, 0, 0, 1, "last");
        cycle(32'h1A1D, 0, 0, 0, 0, 1, "mid_rd");
        cycle(32'h1920, 1, 0, 0, 0, 1, "below");
        cycle(32'h1D2F, 1, 0, 0, 0, 1, "above");
        cycle(32'h1D2E, 1, 0, 0, 0, 1, "just_above");
        cycle(32'h192D, 1, 0, 0, 0, 1, "just_below");
        cycle(32'hFFFF_FFFF, 1, 0, 0, 0, 1, "top");
        // Decode must ignore rst
        cycle(32'h1930, 1, 0, 0, 1, 1, "decode_in_rst");

        cycle(32'h1D2F, 1, 1, 0, 0, 1, "fault1");
        cycle(32'h1920, 0, 1, 0, 0, 1, "fault2");
        cycle(32'h1930, 1, 1, 0, 0, 1, "valid_in_window");
        cycle(32'h0, 0, 1, 1, 0, 1, "clr_with_fault");
        cycle(32'h5, 0, 1, 0, 0, 1, "fault_rd");
        cycle(32'h6, 1, 1, 1, 1, 1, "rst_over_clr");

        for (int i = 0; i < 400; i++) begin
            bit av = ($urandom_range(3) != 0);
            bit clr = ($urandom_range(19) == 0);
            bit r = ($urandom_range(49) == 0);
            cycle(rand_addr(), 1'($urandom), av, clr, r, 1, "rand");
        end

`ifdef ADDR_DECODE_ERR_CAPTURE_EN
        cycle(32'h0, 0, 0, 0, 1, 1, "pre_sat_rst");
        for (int i = 0; i < 65536; i++) begin
            cycle(32'h1920, 1, 1, 0, 0, 0, "sat");
        end
        check_err("saturate");
        cycle(32'h1D2F, 0, 1, 0, 0, 1, "sat_hold");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
